// File: rtl/wr_share_pkg.sv
// -----------------------------------------------------------------------------
// wr_share_pkg
// Shared definitions for the write-share controller and the bus interface that
// consumes its FIFO entries.
//   - ws_state_t      : arbiter state encoding (idle / burst-locked)
//   - min_id_w()      : smallest source-ID width able to name N_REQ requesters
//   - entry_*()       : layout of one FIFO entry, {id, data}, data in the LSBs
// -----------------------------------------------------------------------------
package wr_share_pkg;

    typedef enum logic {
        WS_IDLE   = 1'b0,
        WS_LOCKED = 1'b1
    } ws_state_t;

    // ID_W must satisfy 2**ID_W >= N_REQ.
    function automatic int min_id_w(input int n_req);
        return (n_req <= 1) ? 1 : $clog2(n_req);
    endfunction

    // Entry layout: {id[ID_W-1:0], data[WIDTH-1:0]}.
    function automatic int entry_data_lsb();
        return 0;
    endfunction

    function automatic int entry_id_lsb(input int width);
        return width;
    endfunction

    function automatic int entry_w(input int width, input int id_w);
        return width + id_w;
    endfunction

endpackage

// File: rtl/wr_share_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// wr_rr_pick
// Combinational rotating-priority picker: grants the first set bit of req,
// searching upward from ptr and wrapping modulo N_REQ.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  ID_W   index with highest priority (must be < N_REQ)
//   grant out N_REQ  one-hot grant (all zero when no request)
//   idx   out ID_W   binary index of the granted bit
//   any   out 1      at least one request present
// -----------------------------------------------------------------------------
module wr_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            // Inner loop keeps every bit select constant after unrolling.
            for (int i = 0; i < N_REQ; i++) begin
                if (!any && (i == cand) && req[i]) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = i[ID_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/wr_share_ctrl.sv
// -----------------------------------------------------------------------------
// wr_share_ctrl
// Arbitrates N_REQ write requesters onto the write port of a shared bypass FIFO
// (round-robin, burst locked, each entry tagged with its source ID) and drives
// the FIFO read port from a downstream valid/ready consumer. When the FIFO is
// empty its bypass path forwards a same-cycle write straight to the output.
//
// Optional build macro: WR_SHARE_STRICT_PRIO0_EN
//   defined   : requester 0 wins every IDLE arbitration it requests; the others
//               round-robin among themselves (rr_ptr never points at 0).
//   undefined : pure round-robin.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/last/data   per-requester beat, burst end, packed payload
//   req_ready             one-hot beat accepted this cycle
//   fifo_write/indata     FIFO write strobe and {id, data} entry
//   fifo_full             FIFO full
//   fifo_read/outdata     FIFO read strobe and head (bypassed when empty)
//   fifo_empty            FIFO empty
//   out_valid/ready       downstream handshake
//   out_data/out_id       payload and source ID of the head beat
//   busy                  burst in progress or FIFO holds data
// -----------------------------------------------------------------------------
module wr_share_ctrl
    import wr_share_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*WIDTH-1:0]  req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    fifo_write,
    output logic [WIDTH+ID_W-1:0]   fifo_indata,
    input  logic                    fifo_full,
    output logic                    fifo_read,
    input  logic [WIDTH+ID_W-1:0]   fifo_outdata,
    input  logic                    fifo_empty,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    busy
);

    localparam int ID_LSB   = entry_id_lsb(WIDTH);
    localparam int DATA_LSB = entry_data_lsb();

    ws_state_t        state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  owner_reg;

    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

    logic [N_REQ-1:0] grant_oh;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;
    logic             space;
    logic             accept;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

`ifdef WR_SHARE_STRICT_PRIO0_EN
    // Requester 0 is handled outside the rotation.
    assign pick_req = {req_valid[N_REQ-1:1], 1'b0};
`else
    assign pick_req = req_valid;
`endif

    wr_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Pointer after idx, wrapping N_REQ-1 back to the start of the rotation.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
        logic [ID_W-1:0] n;
        if (int'(idx) >= N_REQ - 1) begin
`ifdef WR_SHARE_STRICT_PRIO0_EN
            n = ID_W'(1);
`else
            n = '0;
`endif
        end else begin
            n = idx + ID_W'(1);
        end
        return n;
    endfunction

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (state_reg == WS_LOCKED) begin
            // Lock holds even while the owner idles: nobody else may steal.
            grant_idx = owner_reg;
            for (int i = 0; i < N_REQ; i++) begin
                if (owner_reg == i[ID_W-1:0]) begin
                    grant_oh[i] = req_valid[i];
                    grant_any   = req_valid[i];
                end
            end
        end else begin
`ifdef WR_SHARE_STRICT_PRIO0_EN
            if (req_valid[0]) begin
                grant_oh[0] = 1'b1;
                grant_any   = 1'b1;
            end else begin
                grant_oh  = pick_grant;
                grant_idx = pick_idx;
                grant_any = pick_any;
            end
`else
            grant_oh  = pick_grant;
            grant_idx = pick_idx;
            grant_any = pick_any;
`endif
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_data = data_arr[i];
                grant_last = req_last[i];
            end
        end
    end

    // A full FIFO is never empty, so a pending head read frees a slot this
    // cycle. Deriving space from the head read alone keeps write and read
    // strobes free of a combinational loop.
    assign space  = ~fifo_full | (~fifo_empty & out_ready);
    assign accept = grant_any & space & ~reset;

    assign req_ready   = {N_REQ{accept}} & grant_oh;
    assign fifo_write  = accept;
    assign fifo_indata = {grant_idx, grant_data};

    assign out_valid = ~fifo_empty | fifo_write;
    assign fifo_read = out_valid & out_ready;
    assign out_data  = fifo_outdata[DATA_LSB +: WIDTH];
    assign out_id    = fifo_outdata[ID_LSB +: ID_W];
    assign busy      = (state_reg != WS_IDLE) | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= WS_IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else if (accept) begin
            case (state_reg)
                WS_IDLE: begin
                    if (grant_last) begin
`ifdef WR_SHARE_STRICT_PRIO0_EN
                        // Priority wins by requester 0 leave the rotation alone.
                        if (grant_idx != '0) begin
                            rr_ptr_reg <= next_ptr(grant_idx);
                        end
`else
                        rr_ptr_reg <= next_ptr(grant_idx);
`endif
                    end else begin
                        owner_reg <= grant_idx;
                        state_reg <= WS_LOCKED;
                    end
                end
                WS_LOCKED: begin
                    if (grant_last) begin
                        state_reg  <= WS_IDLE;
                        rr_ptr_reg <= next_ptr(owner_reg);
                    end
                end
                default: state_reg <= WS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_share_ctrl
// Directed bench for wr_share_ctrl (WIDTH=32, N_REQ=4, ID_W=2) with a 4-deep
// behavioural bypass FIFO attached to the FIFO ports.
// -----------------------------------------------------------------------------
module tb_wr_share_ctrl;

    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int DEPTH = 4;
    localparam int EW    = WIDTH + ID_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_write;
    logic [EW-1:0]          fifo_indata;
    logic                   fifo_full;
    logic                   fifo_read;
    logic [EW-1:0]          fifo_outdata;
    logic                   fifo_empty;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [ID_W-1:0]        out_id;
    logic                   busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wr_share_ctrl #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_write   (fifo_write),
        .fifo_indata  (fifo_indata),
        .fifo_full    (fifo_full),
        .fifo_read    (fifo_read),
        .fifo_outdata (fifo_outdata),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .busy         (busy)
    );

    // Behavioural bypass FIFO.
    logic [EW-1:0] mem [DEPTH];
    int cnt = 0;
    int wp  = 0;
    int rp  = 0;
    logic push;
    logic pop;

    assign fifo_empty   = (cnt == 0);
    assign fifo_full    = (cnt == DEPTH);
    assign fifo_outdata = (cnt == 0) ? fifo_indata : mem[rp];
    assign push = fifo_write & ~(fifo_read & (cnt == 0));
    assign pop  = fifo_read & (cnt != 0);

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0;
            wp  <= 0;
            rp  <= 0;
        end else begin
            if (push) begin
                mem[wp] <= fifo_indata;
                wp      <= (wp + 1) % DEPTH;
            end
            if (pop) begin
                rp <= (rp + 1) % DEPTH;
            end
            cnt <= cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the drive point of the next cycle (well clear of posedge).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic [3:0] v, input logic [3:0] l);
        req_valid = v;
        req_last  = l;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        logic [3:0] exp_oh;

        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // ---- reset state ----
        tick(); tick(); settle();
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_fifo_write", fifo_write, 1'b0);
        chk("rst_fifo_read", fifo_read, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        $display("txn reset: req_ready=%b out_valid=%b busy=%b", req_ready, out_valid, busy);

        // ---- zero-latency bypass, requester 2 ----
        reset     = 1'b0;
        out_ready = 1'b1;
        set_data(2, 32'hDEADBEEF);
        set_req(4'b0100, 4'b0100);
        settle();
        chk("byp_req_ready", req_ready, 4'b0100);
        chk("byp_out_valid", out_valid, 1'b1);
        chk("byp_out_data", out_data, 32'hDEADBEEF);
        chk("byp_out_id", out_id, 2'd2);
        chk("byp_fifo_read", fifo_read, 1'b1);
        $display("txn bypass: id=%0d data=%h", out_id, out_data);
        tick();
        set_req(4'b0000, 4'b0000);
        settle();
        chk("byp_count", cnt, 0);
        chk("byp_busy", busy, 1'b0);

        // ---- requester 3 single beat moves rr_ptr to 0 ----
        set_data(3, 32'h0000_0033);
        set_req(4'b1000, 4'b1000);
        settle();
        chk("r3_req_ready", req_ready, 4'b1000);
        chk("r3_out_id", out_id, 2'd3);
        $display("txn single: id=%0d data=%h", out_id, out_data);
        tick();

        // ---- all four valid, single beats: 0,1,2,3,0 ----
        for (int i = 0; i < N_REQ; i++) set_data(i, 32'h100 + i);
        set_req(4'b1111, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            settle();
            exp_oh = 4'b0001 << (k % 4);
            chk("rr_req_ready", req_ready, exp_oh);
            chk("rr_out_id", out_id, k % 4);
            chk("rr_out_data", out_data, 32'h100 + (k % 4));
            $display("txn rr: id=%0d data=%h", out_id, out_data);
            tick();
        end
        // rr_ptr is now 1.

        // ---- burst by requester 1 while 0 and 3 wait ----
        set_data(1, 32'hB1);
        set_req(4'b1011, 4'b1001);
        settle();
        chk("burst_b1_ready", req_ready, 4'b0010);
        chk("burst_b1_data", out_data, 32'hB1);
        chk("burst_b1_id", out_id, 2'd1);
        $display("txn burst: id=%0d data=%h", out_id, out_data);
        tick();
        set_data(1, 32'hB2);
        settle();
        chk("burst_b2_ready", req_ready, 4'b0010);
        chk("burst_b2_data", out_data, 32'hB2);
        chk("burst_busy", busy, 1'b1);
        $display("txn burst: id=%0d data=%h", out_id, out_data);
        tick();
        // Owner idles: lock must hold, others stay blocked.
        set_req(4'b1001, 4'b1001);
        settle();
        chk("burst_hole_ready", req_ready, 4'b0000);
        chk("burst_hole_valid", out_valid, 1'b0);
        $display("txn burst hole: req_ready=%b", req_ready);
        tick();
        set_data(1, 32'hB3);
        set_req(4'b1011, 4'b1011);
        settle();
        chk("burst_b3_ready", req_ready, 4'b0010);
        chk("burst_b3_data", out_data, 32'hB3);
        $display("txn burst: id=%0d data=%h", out_id, out_data);
        tick();
        set_req(4'b1001, 4'b1001);
        settle();
        chk("post_burst_r3", req_ready, 4'b1000);
        chk("post_burst_r3_id", out_id, 2'd3);
        $display("txn after burst: id=%0d", out_id);
        tick();
        settle();
        chk("post_burst_r0", req_ready, 4'b0001);
        chk("post_burst_r0_id", out_id, 2'd0);
        $display("txn after burst: id=%0d", out_id);
        tick();

        // ---- fill FIFO with out_ready low ----
        out_ready = 1'b0;
        set_req(4'b0001, 4'b0001);
        for (int k = 0; k < DEPTH; k++) begin
            set_data(0, 32'hA0 + k);
            settle();
            chk("fill_req_ready", req_ready, 4'b0001);
            chk("fill_out_valid", out_valid, 1'b1);
            $display("txn fill: data=%h count=%0d", fifo_indata[31:0], cnt);
            tick();
        end
        set_data(0, 32'hA4);
        settle();
        chk("full_count", cnt, DEPTH);
        chk("full_req_ready", req_ready, 4'b0000);
        chk("full_fifo_write", fifo_write, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        chk("full_head", out_data, 32'hA0);
        $display("txn full: req_ready=%b head=%h", req_ready, out_data);
        tick();
        settle();
        chk("full_hold_ready", req_ready, 4'b0000);
        chk("full_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        settle();
        chk("full_rw_ready", req_ready, 4'b0001);
        chk("full_rw_read", fifo_read, 1'b1);
        chk("full_rw_write", fifo_write, 1'b1);
        chk("full_rw_head", out_data, 32'hA0);
        $display("txn full read+write: head=%h", out_data);
        tick();
        set_req(4'b0000, 4'b0000);
        settle();
        chk("full_rw_count", cnt, DEPTH);
        for (int k = 1; k <= DEPTH; k++) begin
            settle();
            chk("drain_data", out_data, 32'hA0 + k);
            chk("drain_id", out_id, 2'd0);
            $display("txn drain: id=%0d data=%h", out_id, out_data);
            tick();
        end
        settle();
        chk("drain_empty_valid", out_valid, 1'b0);
        chk("drain_busy", busy, 1'b0);

        // ---- reset mid-burst ----
        set_data(2, 32'hC2);
        set_req(4'b0100, 4'b0100);
        settle();
        chk("pre_rst_single", req_ready, 4'b0100);
        tick();
        // rr_ptr is now 3; start a burst from requester 2.
        set_req(4'b0100, 4'b0000);
        settle();
        chk("pre_rst_burst", req_ready, 4'b0100);
        tick();
        reset = 1'b1;
        set_req(4'b1111, 4'b0000);
        settle();
        chk("in_rst_ready", req_ready, 4'b0000);
        chk("in_rst_write", fifo_write, 1'b0);
        $display("txn reset mid-burst: req_ready=%b", req_ready);
        tick();
        reset = 1'b0;
        set_req(4'b1010, 4'b1010);
        settle();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_grant", req_ready, 4'b0010);
        chk("post_rst_id", out_id, 2'd1);
        $display("txn post reset: id=%0d", out_id);
        tick();

        // ---- requester-0 priority vs pure round-robin ----
        reset = 1'b1;
        set_req(4'b0000, 4'b0000);
        tick();
        reset = 1'b0;
        set_req(4'b1111, 4'b1111);
`ifdef WR_SHARE_STRICT_PRIO0_EN
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("prio0_ready", req_ready, 4'b0001);
            $display("txn prio: id=%0d", out_id);
            tick();
        end
        set_req(4'b1110, 4'b1110);
        settle();
        chk("prio_rr_1", req_ready, 4'b0010);
        tick();
        settle();
        chk("prio_rr_2", req_ready, 4'b0100);
        tick();
        settle();
        chk("prio_rr_3", req_ready, 4'b1000);
        tick();
        settle();
        chk("prio_rr_wrap", req_ready, 4'b0010);
        $display("txn prio rr wrap: id=%0d", out_id);
        tick();
`else
        for (int k = 0; k < 3; k++) begin
            settle();
            exp_oh = 4'b0001 << k;
            chk("rr2_ready", req_ready, exp_oh);
            $display("txn rr: id=%0d", out_id);
            tick();
        end
        set_req(4'b1110, 4'b1110);
        settle();
        chk("rr2_r3", req_ready, 4'b1000);
        tick();
        settle();
        chk("rr2_wrap", req_ready, 4'b0010);
        $display("txn rr wrap: id=%0d", out_id);
        tick();
`endif
        set_req(4'b0000, 4'b0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_share_ctrl.md
Name: wr_share_ctrl

Overview:
- Arbitrates N_REQ write requesters (store buffer, uncached-write path, cache writeback, ...) onto the single write port of a shared bypass FIFO.
- Drives that FIFO's read port from a downstream valid/ready consumer (bus interface).
- Round-robin with burst locking; each entry is tagged with its source ID.
- Exploits the FIFO's empty-bypass path so an empty queue forwards in zero cycles.

Parameters:
- WIDTH, 32, payload width per beat.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, source-ID width; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester final beat of burst.
- req_data  in  N_REQ*WIDTH  packed payloads; requester i at [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot beat accepted this cycle.
- fifo_write  out  1  FIFO write strobe.
- fifo_indata  out  WIDTH+ID_W  {id, data} to FIFO.
- fifo_full  in  1  FIFO full.
- fifo_read  out  1  FIFO read strobe.
- fifo_outdata  in  WIDTH+ID_W  FIFO head (bypassed when empty and read).
- fifo_empty  in  1  FIFO empty.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  fifo_outdata[WIDTH-1:0].
- out_id  out  ID_W  fifo_outdata[WIDTH+ID_W-1:WIDTH].
- busy  out  1  state != IDLE, or FIFO not empty.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr=0; owner=0.
  - req_ready=0, fifo_write=0, fifo_read=0, out_valid=0, busy=0.
  - Reset mid-burst aborts the burst; no grant in the reset cycle.
- Write side (combinational accept, registered state):
  - A beat from requester i is accepted iff it is granted, req_valid[i]=1, and (fifo_full=0 or fifo_read=1).
  - On acceptance: req_ready[i]=1, fifo_write=1, fifo_indata={i, data_i}.
  - At most one accept per cycle.
- State IDLE:
  - Grant goes to the first requester with req_valid set, searching from rr_ptr upward modulo N_REQ.
  - Accepted beat with req_last=1: stay IDLE; rr_ptr <= i+1 (wraps N_REQ-1 -> 0).
  - Accepted beat with req_last=0: owner <= i, go to LOCKED.
- State LOCKED:
  - Only owner may be granted; all other requesters see req_ready=0 even if the FIFO has space.
  - owner deasserting req_valid holds the lock; no bubble-steal.
  - Accepted beat with req_last=1: go to IDLE; rr_ptr <= owner+1.
- Read side:
  - out_valid = ~fifo_empty | fifo_write.
  - fifo_read = out_valid & out_ready.
  - Empty FIFO with same-cycle write and read: the beat passes through with 0-cycle latency and FIFO count is unchanged.
  - Non-empty FIFO: strict FIFO order; latency >= 1 cycle.
- Full with simultaneous read: the write is accepted (count unchanged). Full without read: req_ready=0 and state holds.
- out_valid must not drop while out_ready=0 unless reset.
- ID tagging: out_id equals the index of the accepting requester for every beat.

Optional Feature:
- Macro: WR_SHARE_STRICT_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever req_valid[0]=1; the remaining requesters are round-robin among themselves; rr_ptr skips index 0. LOCKED bursts are never preempted.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package holds:
  - state encoding (WS_IDLE=1'b0, WS_LOCKED=1'b1);
  - the ID_W-from-N_REQ rule;
  - the {id, data} entry layout offsets, also used by the bus interface.
- One natural sub-module, wr_rr_pick: combinational rotating-priority picker. Inputs: request vector, rr_ptr. Outputs: one-hot grant and binary index.
- The bypass FIFO itself is instantiated by the parent, not inside this block.

Test Plan:
- Empty FIFO, out_ready=1, req_valid=4'b0100, last=1, data=0xDEADBEEF -> same cycle: req_ready=4'b0100, out_valid=1, out_data=0xDEADBEEF, out_id=2; FIFO count stays 0.
- All four requesters valid with single-beat bursts, out_ready=1, rr_ptr=0 -> grant order 0,1,2,3,0 on consecutive cycles; out_id follows the same order.
- Requester 1 issues a 3-beat burst (last on beat 3) while requesters 0 and 3 are valid -> beats 1..3 are consecutive with id=1; requester 3 is granted next, then 0.
- out_ready=0, requester 0 streams until fifo_full -> req_ready=0 and data held; raising out_ready for 1 cycle -> one read and one write in the same cycle, data order preserved.
- Reset asserted in LOCKED mid-burst -> next cycle state IDLE, rr_ptr=0, req_ready=0, fifo_write=0; the first post-reset grant goes to the lowest valid index.
- With WR_SHARE_STRICT_PRIO0_EN defined, req_valid=4'b1111 persistent -> requester 0 is granted every IDLE cycle; other requesters receive no grant while req_valid[0]=1.
